// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared alu opcodes, widths and execute-stage state encoding
package alu_pkg;

    localparam int DEF_WIDTH_DATA    = 16;
    localparam int DEF_WIDTH_CONTROL = 4;

    localparam logic [DEF_WIDTH_CONTROL-1:0] OP_ADD  = 4'd0;
    localparam logic [DEF_WIDTH_CONTROL-1:0] OP_SUB  = 4'd1;
    localparam logic [DEF_WIDTH_CONTROL-1:0] OP_CMP  = 4'd2;
    localparam logic [DEF_WIDTH_CONTROL-1:0] OP_AND  = 4'd3;
    localparam logic [DEF_WIDTH_CONTROL-1:0] OP_OR   = 4'd4;
    localparam logic [DEF_WIDTH_CONTROL-1:0] OP_XOR  = 4'd5;
    localparam logic [DEF_WIDTH_CONTROL-1:0] OP_LSH  = 4'd6;
    localparam logic [DEF_WIDTH_CONTROL-1:0] OP_LAST = OP_LSH;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_READ = 2'd1,
        ST_EXEC = 2'd2,
        ST_WB   = 2'd3
    } state_t;

    function automatic logic is_legal_op(input logic [DEF_WIDTH_CONTROL-1:0] op);
        return op <= OP_LAST;
    endfunction

endpackage

// File: rtl/alu_exec_stage_regfile.sv
// rtl/alu_exec_stage_regfile.sv - register file, one write port, two registered read ports, async debug read
module alu_exec_stage_regfile #(
    parameter int NUM_REGS   = 16,
    parameter int WIDTH_DATA = 16,
    parameter int WIDTH_ADDR = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_en,
    input  logic [WIDTH_ADDR-1:0] wr_addr,
    input  logic [WIDTH_DATA-1:0] wr_data,
    input  logic                  rd_en,
    input  logic [WIDTH_ADDR-1:0] rd_addr_a,
    input  logic [WIDTH_ADDR-1:0] rd_addr_b,
    input  logic                  rd_b_force,
    input  logic [WIDTH_DATA-1:0] rd_b_force_data,
    output logic [WIDTH_DATA-1:0] rd_data_a,
    output logic [WIDTH_DATA-1:0] rd_data_b,
    input  logic [WIDTH_ADDR-1:0] dbg_addr,
    output logic [WIDTH_DATA-1:0] dbg_data
);

    logic [WIDTH_DATA-1:0] mem [NUM_REGS];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                mem[i] <= '0;
            end
        end else if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Port B can be loaded with a forced value so the operand mux sits
    // before the register and the consumer sees a clean flop output.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data_a <= '0;
            rd_data_b <= '0;
        end else if (rd_en) begin
            rd_data_a <= mem[rd_addr_a];
            rd_data_b <= rd_b_force ? rd_b_force_data : mem[rd_addr_b];
        end
    end

    assign dbg_data = mem[dbg_addr];

endmodule

// File: rtl/alu_exec_stage.sv
// rtl/alu_exec_stage.sv - execute-stage sequencer feeding an external alu and retiring its result
module alu_exec_stage
    import alu_pkg::*;
#(
    parameter int WIDTH_DATA    = DEF_WIDTH_DATA,
    parameter int WIDTH_CONTROL = DEF_WIDTH_CONTROL,
    parameter int NUM_REGS      = 16,
    parameter int WIDTH_ADDR    = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [WIDTH_CONTROL-1:0] in_op,
    input  logic [WIDTH_ADDR-1:0]    in_rdest,
    input  logic [WIDTH_ADDR-1:0]    in_rsrc,
    input  logic [7:0]               in_imm,
    input  logic                     in_use_imm,
    input  logic                     in_use_carry,
    output logic [WIDTH_DATA-1:0]    alu_A,
    output logic [WIDTH_DATA-1:0]    alu_B,
    output logic [WIDTH_CONTROL-1:0] alu_control_word,
    output logic                     alu_carry_in,
    input  logic [WIDTH_DATA-1:0]    alu_result,
    input  logic                     alu_carry_out,
    input  logic                     alu_zero_out,
    output logic                     done,
    output logic                     err,
    output logic                     psr_carry,
    output logic                     psr_zero,
    input  logic [WIDTH_ADDR-1:0]    dbg_addr,
    output logic [WIDTH_DATA-1:0]    dbg_data
);

    state_t state_q, state_d;

    logic [WIDTH_CONTROL-1:0] op_q;
    logic [WIDTH_ADDR-1:0]    rdest_q, rsrc_q;
    logic [7:0]               imm_q;
    logic                     use_imm_q, use_carry_q;
    logic                     cin_q;
    logic [WIDTH_DATA-1:0]    a_q, b_q, res_q;
    logic                     c_q, z_q;

    logic accept, rd_en, wr_en, flag_en, op_legal;

    assign accept   = in_valid && in_ready;
    assign op_legal = is_legal_op(op_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        in_ready = 1'b0;
        rd_en    = 1'b0;
        wr_en    = 1'b0;
        flag_en  = 1'b0;
        done     = 1'b0;
        err      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_d = ST_READ;
                end
            end
            ST_READ: begin
                rd_en   = 1'b1;
                state_d = ST_EXEC;
            end
            ST_EXEC: begin
                state_d = ST_WB;
            end
            ST_WB: begin
                done    = 1'b1;
                err     = !op_legal;
                flag_en = op_legal;
                wr_en   = op_legal && (op_q != OP_CMP);
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q        <= '0;
            rdest_q     <= '0;
            rsrc_q      <= '0;
            imm_q       <= '0;
            use_imm_q   <= 1'b0;
            use_carry_q <= 1'b0;
        end else if (accept) begin
            op_q        <= in_op;
            rdest_q     <= in_rdest;
            rsrc_q      <= in_rsrc;
            imm_q       <= in_imm;
            use_imm_q   <= in_use_imm;
            use_carry_q <= in_use_carry;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cin_q <= 1'b0;
        end else if (rd_en) begin
            cin_q <= use_carry_q & psr_carry;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_q <= '0;
            c_q   <= 1'b0;
            z_q   <= 1'b0;
        end else if (state_q == ST_EXEC) begin
            res_q <= alu_result;
            c_q   <= alu_carry_out;
            z_q   <= alu_zero_out;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            psr_carry <= 1'b0;
            psr_zero  <= 1'b0;
        end else if (flag_en) begin
            psr_carry <= c_q;
            psr_zero  <= z_q;
        end
    end

    // Operand registers a_q/b_q are the regfile's read-port flops.
    alu_exec_stage_regfile #(
        .NUM_REGS   (NUM_REGS),
        .WIDTH_DATA (WIDTH_DATA),
        .WIDTH_ADDR (WIDTH_ADDR)
    ) u_regfile (
        .clk             (clk),
        .rst_n           (rst_n),
        .wr_en           (wr_en),
        .wr_addr         (rdest_q),
        .wr_data         (res_q),
        .rd_en           (rd_en),
        .rd_addr_a       (rdest_q),
        .rd_addr_b       (rsrc_q),
        .rd_b_force      (use_imm_q),
        .rd_b_force_data ({{(WIDTH_DATA-8){1'b0}}, imm_q}),
        .rd_data_a       (a_q),
        .rd_data_b       (b_q),
        .dbg_addr        (dbg_addr),
        .dbg_data        (dbg_data)
    );

    assign alu_A            = a_q;
    assign alu_B            = b_q;
    assign alu_control_word = op_q;
    assign alu_carry_in     = cin_q;

endmodule

// File: tb/tb_alu_exec_stage.sv
// tb/tb_alu_exec_stage.sv - self-checking bench for alu_exec_stage with a behavioural alu and stage model
module tb_alu_exec_stage;
    import alu_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  in_op;
    logic [3:0]  in_rdest;
    logic [3:0]  in_rsrc;
    logic [7:0]  in_imm;
    logic        in_use_imm;
    logic        in_use_carry;
    logic [15:0] alu_A, alu_B, alu_result;
    logic [3:0]  alu_control_word;
    logic        alu_carry_in, alu_carry_out, alu_zero_out;
    logic        done, err, psr_carry, psr_zero;
    logic [3:0]  dbg_addr;
    logic [15:0] dbg_data;

    int n_checks = 0;
    int n_fail   = 0;

    logic [15:0] rf_m [16];
    logic        pc_m, pz_m;

    always #5 clk = ~clk;

    // Returns {carry, zero, result}; SUB/CMP report borrow as carry.
    function automatic logic [17:0] alu_fn(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b, input logic cin);
        logic [16:0] s;
        s = '0;
        case (op)
            4'd0:       s = {1'b0, a} + {1'b0, b} + {16'b0, cin};
            4'd1, 4'd2: s = {1'b0, a} - {1'b0, b} - {16'b0, cin};
            4'd3:       s = {1'b0, a & b};
            4'd4:       s = {1'b0, a | b};
            4'd5:       s = {1'b0, a ^ b};
            4'd6:       s = {1'b0, a << b[3:0]};
            default:    s = '0;
        endcase
        return {s[16], (s[15:0] == 16'h0), s[15:0]};
    endfunction

    logic [17:0] alu_out;
    assign alu_out       = alu_fn(alu_control_word, alu_A, alu_B, alu_carry_in);
    assign alu_result    = alu_out[15:0];
    assign alu_zero_out  = alu_out[16];
    assign alu_carry_out = alu_out[17];

    alu_exec_stage dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .in_valid         (in_valid),
        .in_ready         (in_ready),
        .in_op            (in_op),
        .in_rdest         (in_rdest),
        .in_rsrc          (in_rsrc),
        .in_imm           (in_imm),
        .in_use_imm       (in_use_imm),
        .in_use_carry     (in_use_carry),
        .alu_A            (alu_A),
        .alu_B            (alu_B),
        .alu_control_word (alu_control_word),
        .alu_carry_in     (alu_carry_in),
        .alu_result       (alu_result),
        .alu_carry_out    (alu_carry_out),
        .alu_zero_out     (alu_zero_out),
        .done             (done),
        .err              (err),
        .psr_carry        (psr_carry),
        .psr_zero         (psr_zero),
        .dbg_addr         (dbg_addr),
        .dbg_data         (dbg_data)
    );

    task automatic model_reset();
        for (int i = 0; i < 16; i++) rf_m[i] = 16'h0;
        pc_m = 1'b0;
        pz_m = 1'b0;
    endtask

    task automatic model_retire(input logic [3:0] op, input logic [3:0] rd, input logic [17:0] r);
        if (op <= 4'd6) begin
            if (op != 4'd2) rf_m[rd] = r[15:0];
            pc_m = r[17];
            pz_m = r[16];
        end
    endtask

    task automatic check_all_rf(input string tag);
        for (int i = 0; i < 16; i++) begin
            dbg_addr = 4'(i);
            #1;
            n_checks++;
            if (dbg_data !== rf_m[i]) begin
                n_fail++;
                $display("FAIL %s rf[%0d]: got %h expected %h", tag, i, dbg_data, rf_m[i]);
            end
        end
    endtask

    task automatic issue(input logic [3:0] op, input logic [3:0] rd, input logic [3:0] rs,
                         input logic [7:0] imm, input logic ui, input logic uc);
        logic [15:0] a, b;
        logic        cin;
        logic [17:0] r;
        int          waitc;
        a   = rf_m[rd];
        b   = ui ? {8'h0, imm} : rf_m[rs];
        cin = uc & pc_m;
        r   = alu_fn(op, a, b, cin);
        waitc = 0;
        while (in_ready !== 1'b1 && waitc < 10) begin
            @(negedge clk);
            waitc++;
        end
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL issue_ready_timeout: in_ready=%b expected 1", in_ready);
        end
        in_valid = 1'b1; in_op = op; in_rdest = rd; in_rsrc = rs;
        in_imm = imm; in_use_imm = ui; in_use_carry = uc;
        @(posedge clk);
        #1 in_valid = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            if (k == 2) begin
                n_checks++;
                if ({alu_A, alu_B, alu_control_word, alu_carry_in} !== {a, b, op, cin}) begin
                    n_fail++;
                    $display("FAIL exec_operands op=%0d: got A=%h B=%h cw=%0d cin=%b expected A=%h B=%h cw=%0d cin=%b",
                             op, alu_A, alu_B, alu_control_word, alu_carry_in, a, b, op, cin);
                end
            end
            n_checks++;
            if (done !== (k == 3)) begin
                n_fail++;
                $display("FAIL done_timing cycle %0d after accept: got %b expected %b", k, done, (k == 3));
            end
        end
        n_checks++;
        if (err !== (op > 4'd6)) begin
            n_fail++;
            $display("FAIL err op=%0d: got %b expected %b", op, err, (op > 4'd6));
        end
        model_retire(op, rd, r);
        dbg_addr = rd;
        @(posedge clk);
        #1;
        n_checks++;
        if (dbg_data !== rf_m[rd]) begin
            n_fail++;
            $display("FAIL result op=%0d r%0d: got %h expected %h", op, rd, dbg_data, rf_m[rd]);
        end
        n_checks++;
        if ({psr_carry, psr_zero} !== {pc_m, pz_m}) begin
            n_fail++;
            $display("FAIL psr op=%0d: got c=%b z=%b expected c=%b z=%b", op, psr_carry, psr_zero, pc_m, pz_m);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; in_op = '0; in_rdest = '0; in_rsrc = '0;
        in_imm = '0; in_use_imm = 1'b0; in_use_carry = 1'b0; dbg_addr = '0;
        model_reset();
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        n_checks++;
        if ({in_ready, done, err, psr_carry, psr_zero} !== 5'b10000) begin
            n_fail++;
            $display("FAIL reset_ctrl: got ready/done/err/c/z=%b expected 10000",
                     {in_ready, done, err, psr_carry, psr_zero});
        end
        n_checks++;
        if ({alu_A, alu_B, alu_control_word, alu_carry_in} !== 37'h0) begin
            n_fail++;
            $display("FAIL reset_alu_outputs: got A=%h B=%h cw=%h cin=%b expected all 0",
                     alu_A, alu_B, alu_control_word, alu_carry_in);
        end
        check_all_rf("reset");
    endtask

    task automatic test_add();
        issue(OP_ADD, 4'd1, 4'd0, 8'd5, 1'b1, 1'b0);
        issue(OP_ADD, 4'd1, 4'd0, 8'd6, 1'b1, 1'b0);
        n_checks++;
        if ({rf_m[1], pc_m, pz_m} !== {16'd11, 2'b00}) begin
            n_fail++;
            $display("FAIL add_model_expect: got %h expected 000b", rf_m[1]);
        end
    endtask

    task automatic test_carry_zero();
        issue(OP_SUB, 4'd2, 4'd0, 8'd1, 1'b1, 1'b0);
        issue(OP_ADD, 4'd2, 4'd0, 8'd1, 1'b1, 1'b0);
        n_checks++;
        if ({psr_carry, psr_zero} !== 2'b11) begin
            n_fail++;
            $display("FAIL wrap_flags: got c=%b z=%b expected c=1 z=1", psr_carry, psr_zero);
        end
        issue(OP_ADD, 4'd3, 4'd1, 8'd0, 1'b1, 1'b1);
    endtask

    task automatic test_cmp();
        issue(OP_CMP, 4'd1, 4'd1, 8'd0, 1'b0, 1'b0);
        n_checks++;
        if ({dbg_data, psr_carry, psr_zero} !== {16'd11, 2'b01}) begin
            n_fail++;
            $display("FAIL cmp_r1: got r1=%h c=%b z=%b expected r1=000b c=0 z=1", dbg_data, psr_carry, psr_zero);
        end
    endtask

    task automatic test_illegal();
        issue(4'd9, 4'd1, 4'd2, 8'hAA, 1'b1, 1'b0);
        check_all_rf("illegal");
    endtask

    task automatic test_back_to_back();
        logic [17:0] r;
        int lowcnt;
        lowcnt = 0;
        @(negedge clk);
        in_valid = 1'b1; in_op = OP_ADD; in_rdest = 4'd3; in_rsrc = 4'd0;
        in_imm = 8'd7; in_use_imm = 1'b1; in_use_carry = 1'b0;
        @(posedge clk);
        #1 in_op = OP_ADD; in_rdest = 4'd5; in_rsrc = 4'd3; in_use_imm = 1'b0;
        r = alu_fn(OP_ADD, rf_m[3], 16'd7, 1'b0);
        model_retire(OP_ADD, 4'd3, r);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (in_ready === 1'b1) break;
            lowcnt++;
        end
        n_checks++;
        if (lowcnt !== 3) begin
            n_fail++;
            $display("FAIL b2b_ready_low: got %0d cycles expected 3", lowcnt);
        end
        r = alu_fn(OP_ADD, rf_m[5], rf_m[3], 1'b0);
        @(posedge clk);
        #1 in_valid = 1'b0;
        for (int k = 1; k <= 3; k++) @(negedge clk);
        n_checks++;
        if (done !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_done: got %b expected 1", done);
        end
        model_retire(OP_ADD, 4'd5, r);
        dbg_addr = 4'd5;
        @(posedge clk);
        #1;
        n_checks++;
        if (dbg_data !== rf_m[5]) begin
            n_fail++;
            $display("FAIL b2b_dependent: got r5=%h expected %h", dbg_data, rf_m[5]);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 24; i++) begin
            issue(4'($urandom_range(0, 9)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                  8'($urandom), 1'($urandom), 1'($urandom));
        end
    endtask

    task automatic test_reset_mid();
        logic saw_done;
        saw_done = 1'b0;
        issue(OP_ADD, 4'd6, 4'd0, 8'd9, 1'b1, 1'b0);
        @(negedge clk);
        in_valid = 1'b1; in_op = OP_ADD; in_rdest = 4'd7; in_imm = 8'd3; in_use_imm = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({in_ready, done} !== 2'b10) begin
            n_fail++;
            $display("FAIL reset_mid_immediate: got ready=%b done=%b expected ready=1 done=0", in_ready, done);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (done === 1'b1) saw_done = 1'b1;
        end
        n_checks++;
        if (saw_done !== 1'b0 || {psr_carry, psr_zero} !== 2'b00) begin
            n_fail++;
            $display("FAIL reset_mid_after: got done_seen=%b c=%b z=%b expected 0 0 0", saw_done, psr_carry, psr_zero);
        end
        check_all_rf("reset_mid");
    endtask

    initial begin
        test_reset();
        test_add();
        test_carry_zero();
        test_cmp();
        test_illegal();
        test_back_to_back();
        test_random();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
